// File: rtl/param_datapath.sv
// param_datapath
//   Parametrised CPU datapath: NREGS x WIDTH register file, A/B operand
//   registers, shifter on B, 4-op ALU, result register C and {N,V,Z}
//   status register. The datapath can be driven manually through the
//   control ports, or a built-in sequencer can run one complete
//   register-to-register operation (rd = rn OP shift(rm)) from a single
//   start pulse.
//
// Parameters
//   WIDTH  datapath word width (>= 8)
//   NREGS  register count (power of 2, >= 2)
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   datapath_in                writeback source (vsel=1) / immediate (bsel=1)
//   vsel, writenum, write      manual writeback control
//   readnum                    manual read index
//   loada/loadb/loadc/loads    manual load enables for A, B, C, status
//   shift, asel, bsel, ALUop   manual shifter / operand mux / ALU control
//   start                      launch a sequenced op (only honoured in IDLE)
//   op_rd/op_rn/op_rm          sequenced op register indices
//   op_alu/op_shift            sequenced op ALU op and shift op
//   busy                       sequencer active
//   done                       one-cycle pulse after the sequenced op completes
//   status_out                 {N, V, Z}
//   datapath_out               contents of C
module param_datapath #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] datapath_in,
  input  logic             vsel,
  input  logic [RW-1:0]    writenum,
  input  logic [RW-1:0]    readnum,
  input  logic             write,
  input  logic             loada,
  input  logic             loadb,
  input  logic             loadc,
  input  logic             loads,
  input  logic [1:0]       shift,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       ALUop,
  input  logic             start,
  input  logic [RW-1:0]    op_rd,
  input  logic [RW-1:0]    op_rn,
  input  logic [RW-1:0]    op_rm,
  input  logic [1:0]       op_alu,
  input  logic [1:0]       op_shift,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status_out,
  output logic [WIDTH-1:0] datapath_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  // Shifter applied to the B operand.
  function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] b,
                                                input logic [1:0]       op);
    logic signed [WIDTH-1:0] sb;
    sb = b;
    case (op)
      2'b00:   return b;
      2'b01:   return {b[WIDTH-2:0], 1'b0};
      2'b10:   return {1'b0, b[WIDTH-1:1]};
      default: return $unsigned(sb >>> 1);
    endcase
  endfunction

  // ALU result, wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0]       op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return ~b;
    endcase
  endfunction

  // Two's-complement overflow: the result sign disagrees with what the
  // operand signs force. Logic ops never overflow.
  function automatic logic ovf_fn(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] r,
                                  input logic [1:0]       op);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] sr;
    sa = a;
    sb = b;
    sr = r;
    case (op)
      2'b00:   return ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
      2'b01:   return ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
      default: return 1'b0;
    endcase
  endfunction

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [2:0]       r_status;
  logic             r_done;

  logic [RW-1:0]    r_op_rd;
  logic [RW-1:0]    r_op_rn;
  logic [RW-1:0]    r_op_rm;
  logic [1:0]       r_op_alu;
  logic [1:0]       r_op_shift;

  // Effective controls after the manual/sequencer mux.
  logic [RW-1:0]    w_readnum;
  logic [RW-1:0]    w_writenum;
  logic             w_write;
  logic             w_vsel;
  logic             w_loada;
  logic             w_loadb;
  logic             w_loadc;
  logic             w_loads;
  logic [1:0]       w_shift;
  logic             w_asel;
  logic             w_bsel;
  logic [1:0]       w_aluop;

  logic [WIDTH-1:0] w_rd_data;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_ain;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_alu;
  logic [2:0]       w_flags;
  logic [WIDTH-1:0] w_wb_data;

  // ---- sequencer: state register and latched op fields ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_op_rd    <= '0;
      r_op_rn    <= '0;
      r_op_rm    <= '0;
      r_op_alu   <= '0;
      r_op_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_WB);
      if ((r_state == S_IDLE) && start) begin
        r_op_rd    <= op_rd;
        r_op_rn    <= op_rn;
        r_op_rm    <= op_rm;
        r_op_alu   <= op_alu;
        r_op_shift <= op_shift;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LDA;
      S_LDA:   w_state_nxt = S_LDB;
      S_LDB:   w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // In IDLE the manual ports pass straight through (including any loads
  // issued in the same cycle as start). Outside IDLE the manual ports are
  // ignored and only the step belonging to the current state is enabled.
  always_comb begin
    w_readnum  = readnum;
    w_writenum = writenum;
    w_write    = write;
    w_vsel     = vsel;
    w_loada    = loada;
    w_loadb    = loadb;
    w_loadc    = loadc;
    w_loads    = loads;
    w_shift    = shift;
    w_asel     = asel;
    w_bsel     = bsel;
    w_aluop    = ALUop;
    if (r_state != S_IDLE) begin
      w_readnum  = r_op_rn;
      w_writenum = r_op_rd;
      w_write    = 1'b0;
      w_vsel     = 1'b0;
      w_loada    = 1'b0;
      w_loadb    = 1'b0;
      w_loadc    = 1'b0;
      w_loads    = 1'b0;
      w_shift    = r_op_shift;
      w_asel     = 1'b0;
      w_bsel     = 1'b0;
      w_aluop    = r_op_alu;
    end
    case (r_state)
      S_LDA:   w_loada = 1'b1;
      S_LDB: begin
        w_readnum = r_op_rm;
        w_loadb   = 1'b1;
      end
      S_EXEC: begin
        w_loadc = 1'b1;
        w_loads = 1'b1;
      end
      S_WB:    w_write = 1'b1;
      default: ;
    endcase
  end

  // ---- combinational datapath: read, shift, operand mux, ALU ----
  always_comb begin
    w_rd_data = r_regs[w_readnum];
    w_shifted = shift_fn(r_b, w_shift);
    w_ain     = w_asel ? '0 : r_a;
    w_bin     = w_shifted;
    if (w_bsel) begin
      w_bin      = '0;
      w_bin[4:0] = datapath_in[4:0];
    end
    w_alu     = alu_fn(w_ain, w_bin, w_aluop);
    w_flags   = {w_alu[WIDTH-1], ovf_fn(w_ain, w_bin, w_alu, w_aluop), (w_alu == '0)};
    w_wb_data = w_vsel ? datapath_in : r_c;
  end

  // ---- register file (reset clears it; a WB write coinciding with reset is dropped) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_write) begin
      r_regs[w_writenum] <= w_wb_data;
    end
  end

  // ---- operand, result and status registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
    end else begin
      if (w_loada) r_a      <= w_rd_data;
      if (w_loadb) r_b      <= w_rd_data;
      if (w_loadc) r_c      <= w_alu;
      if (w_loads) r_status <= w_flags;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign status_out   = r_status;
  assign datapath_out = r_c;

endmodule

// File: tb/tb_param_datapath.sv
// Testbench for param_datapath: a WIDTH=16/NREGS=8 instance exercised with
// a vector table, hand-written sequences and randomized sequenced ops
// against a behavioural model, plus a WIDTH=8/NREGS=16 instance.
module tb_param_datapath;
  localparam int W   = 16;
  localparam int N   = 8;
  localparam int RW  = 3;
  localparam int W8  = 8;
  localparam int N8  = 16;
  localparam int RW8 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance signals
  logic          reset;
  logic [W-1:0]  datapath_in;
  logic          vsel, write, loada, loadb, loadc, loads, asel, bsel, start;
  logic [RW-1:0] writenum, readnum, op_rd, op_rn, op_rm;
  logic [1:0]    shift, ALUop, op_alu, op_shift;
  logic          busy, done;
  logic [2:0]    status_out;
  logic [W-1:0]  datapath_out;

  // 8-bit instance signals
  logic           reset8;
  logic [W8-1:0]  datapath_in8;
  logic           vsel8, write8, loada8, loadb8, loadc8, loads8, asel8, bsel8, start8;
  logic [RW8-1:0] writenum8, readnum8, op_rd8, op_rn8, op_rm8;
  logic [1:0]     shift8, ALUop8, op_alu8, op_shift8;
  logic           busy8, done8;
  logic [2:0]     status_out8;
  logic [W8-1:0]  datapath_out8;

  param_datapath #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .reset(reset), .datapath_in(datapath_in), .vsel(vsel),
    .writenum(writenum), .readnum(readnum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .shift(shift), .asel(asel), .bsel(bsel), .ALUop(ALUop), .start(start),
    .op_rd(op_rd), .op_rn(op_rn), .op_rm(op_rm), .op_alu(op_alu), .op_shift(op_shift),
    .busy(busy), .done(done), .status_out(status_out), .datapath_out(datapath_out)
  );

  param_datapath #(.WIDTH(W8), .NREGS(N8)) dut8 (
    .clk(clk), .reset(reset8), .datapath_in(datapath_in8), .vsel(vsel8),
    .writenum(writenum8), .readnum(readnum8), .write(write8),
    .loada(loada8), .loadb(loadb8), .loadc(loadc8), .loads(loads8),
    .shift(shift8), .asel(asel8), .bsel(bsel8), .ALUop(ALUop8), .start(start8),
    .op_rd(op_rd8), .op_rn(op_rn8), .op_rm(op_rm8), .op_alu(op_alu8), .op_shift(op_shift8),
    .busy(busy8), .done(done8), .status_out(status_out8), .datapath_out(datapath_out8)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_reg [N];   // model of the 16-bit register file

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sh;
    logic [1:0]  alu;
    logic [15:0] c;
    logic [2:0]  fl;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    datapath_in = '0; vsel = 0; writenum = '0; readnum = '0; write = 0;
    loada = 0; loadb = 0; loadc = 0; loads = 0; shift = '0; asel = 0; bsel = 0;
    ALUop = '0; start = 0; op_rd = '0; op_rn = '0; op_rm = '0; op_alu = '0; op_shift = '0;
  endtask

  // Behavioural model: plain integer arithmetic on the word values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] alu, input logic [1:0] sh,
                                output logic [W-1:0] res, output logic [2:0] fl);
    int ua, ub, r, sa, sb, sr;
    bit v;
    ua = a;
    ub = b;
    case (sh)
      2'd1: ub = (ub * 2) % 65536;
      2'd2: ub = ub / 2;
      2'd3: ub = ub / 2 + ((ub >= 32768) ? 32768 : 0);
      default: ;
    endcase
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    v  = 0;
    case (alu)
      2'd0: begin r = (ua + ub) % 65536;         sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      2'd1: begin r = (ua - ub + 65536) % 65536; sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      2'd2: r = ua & ub;
      default: r = 65535 - ub;
    endcase
    res = r[W-1:0];
    fl  = {(r >= 32768), v, (r == 0)};
  endfunction

  task automatic mwrite(input int idx, input logic [W-1:0] v);
    writenum = idx[RW-1:0]; datapath_in = v; vsel = 1; write = 1;
    tick();
    write = 0; vsel = 0; datapath_in = '0;
    m_reg[idx] = v;
  endtask

  // Read a register through A -> ALU (A + imm 0) -> C.
  task automatic mread(input int idx, output logic [W-1:0] v);
    readnum = idx[RW-1:0]; loada = 1;
    tick();
    loada = 0; asel = 0; bsel = 1; datapath_in = '0; ALUop = 2'b00; loadc = 1;
    tick();
    loadc = 0; bsel = 0;
    v = datapath_out;
  endtask

  // Launch a sequenced op; any manual controls already set are applied in
  // the start cycle too. Records busy/done for cycles k+1..k+6 and C at k+4.
  task automatic seq_op(input int rd, input int rn, input int rm,
                        input logic [1:0] alu, input logic [1:0] sh,
                        output logic [W-1:0] c4, output logic [5:0] bh, output logic [5:0] dh);
    op_rd = rd[RW-1:0]; op_rn = rn[RW-1:0]; op_rm = rm[RW-1:0];
    op_alu = alu; op_shift = sh; start = 1;
    tick();
    idle_inputs();
    c4 = '0;
    for (int i = 0; i < 6; i++) begin
      bh[i] = busy;
      dh[i] = done;
      if (i == 3) c4 = datapath_out;
      tick();
    end
  endtask

  // Sequenced op checked against the model (old operand values used).
  task automatic run_op(input int rd, input int rn, input int rm,
                        input logic [1:0] alu, input logic [1:0] sh);
    logic [W-1:0] c4, er;
    logic [5:0]   bh, dh;
    logic [2:0]   ef;
    model(m_reg[rn], m_reg[rm], alu, sh, er, ef);
    seq_op(rd, rn, rm, alu, sh, c4, bh, dh);
    check("rand_c", c4, er);
    check("rand_status", status_out, ef);
    check("rand_timing", {bh, dh}, {6'b001111, 6'b010000});
    m_reg[rd] = er;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rv, c4;
    logic [5:0]   bh, dh;
    int           dcount, bcount;

    vt[0] = '{16'h0007, 16'h0002, 2'b01, 2'b00, 16'h000B, 3'b000};
    vt[1] = '{16'h0005, 16'h0005, 2'b00, 2'b01, 16'h0000, 3'b001};
    vt[2] = '{16'h7FFF, 16'h0001, 2'b00, 2'b00, 16'h8000, 3'b110};
    vt[3] = '{16'h1234, 16'h8000, 2'b11, 2'b10, 16'h0000, 3'b001};
    vt[4] = '{16'h0000, 16'h00F0, 2'b10, 2'b11, 16'hFF87, 3'b100};
    vt[5] = '{16'h8000, 16'h0001, 2'b00, 2'b01, 16'h7FFF, 3'b010};
    vt[6] = '{16'hFFFF, 16'h8001, 2'b01, 2'b00, 16'h0001, 3'b000};
    vt[7] = '{16'h00FF, 16'h0F0F, 2'b00, 2'b10, 16'h000F, 3'b000};

    idle_inputs();
    reset = 1;
    datapath_in8 = '0; vsel8 = 0; writenum8 = '0; readnum8 = '0; write8 = 0;
    loada8 = 0; loadb8 = 0; loadc8 = 0; loads8 = 0; shift8 = '0; asel8 = 0; bsel8 = 0;
    ALUop8 = '0; start8 = 0; op_rd8 = '0; op_rn8 = '0; op_rm8 = '0; op_alu8 = '0; op_shift8 = '0;
    reset8 = 1;
    tick(); tick();
    reset = 0; reset8 = 0;
    for (int i = 0; i < N; i++) m_reg[i] = '0;

    // Reset state
    check("rst_out", datapath_out, 16'h0);
    check("rst_status", status_out, 3'b000);
    check("rst_busy_done", {busy, done}, 2'b00);

    // Preload, dirty C and status, then reset again
    for (int i = 0; i < N; i++) mwrite(i, 16'h1000 + 16'(i) * 16'h111 + 16'h1);
    run_op(0, 1, 2, 2'b01, 2'b00);
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < N; i++) m_reg[i] = '0;
    check("rst2_out", datapath_out, 16'h0);
    check("rst2_status", status_out, 3'b000);
    check("rst2_busy_done", {busy, done}, 2'b00);
    for (int i = 0; i < N; i++) begin
      mread(i, rv);
      check("rst2_reg", rv, 16'h0);
    end

    // Manual path: R0=7, R1=2, A=R0, B=R1, (2<<1)+7
    mwrite(0, 16'd7);
    mwrite(1, 16'd2);
    readnum = 3'd0; loada = 1; tick(); loada = 0;
    readnum = 3'd1; loadb = 1; tick(); loadb = 0;
    shift = 2'b01; ALUop = 2'b00; asel = 0; bsel = 0; loadc = 1; loads = 1;
    tick();
    idle_inputs();
    check("man_c", datapath_out, 16'd11);
    check("man_status", status_out, 3'b000);

    // Vector table through the sequencer
    for (int i = 0; i < 8; i++) begin
      mwrite(1, vt[i].a);
      mwrite(2, vt[i].b);
      seq_op(3, 1, 2, vt[i].alu, vt[i].sh, c4, bh, dh);
      check("vec_c", c4, vt[i].c);
      check("vec_status", status_out, vt[i].fl);
      m_reg[3] = vt[i].c;
    end

    // Sequenced sub with full timing check
    mwrite(2, 16'd5);
    mwrite(3, 16'd5);
    mwrite(4, 16'hABCD);
    seq_op(4, 2, 3, 2'b01, 2'b00, c4, bh, dh);
    check("sub_c_k4", c4, 16'h0);
    check("sub_busy", bh, 6'b001111);
    check("sub_done", dh, 6'b010000);
    check("sub_status", status_out, 3'b001);
    mread(4, rv);
    check("sub_r4", rv, 16'h0);
    m_reg[4] = '0;

    // Overflow, then arithmetic shift of the 0x8000 result
    mwrite(0, 16'h7FFF);
    mwrite(1, 16'h0001);
    seq_op(2, 0, 1, 2'b00, 2'b00, c4, bh, dh);
    check("ovf_c", c4, 16'h8000);
    check("ovf_status", status_out, 3'b110);
    mwrite(6, 16'h0);
    seq_op(5, 6, 2, 2'b00, 2'b11, c4, bh, dh);
    check("asr_c", c4, 16'hC000);
    check("asr_status", status_out, 3'b100);
    mread(5, rv);
    check("asr_r5", rv, 16'hC000);
    m_reg[2] = 16'h8000;
    m_reg[5] = 16'hC000;

    // Start and manual write in the same IDLE cycle: R7=0x55 lands first
    writenum = 3'd7; datapath_in = 16'h0055; vsel = 1; write = 1;
    seq_op(0, 7, 7, 2'b00, 2'b00, c4, bh, dh);
    check("same_cycle_c", c4, 16'h00AA);
    mread(7, rv);
    check("same_cycle_r7", rv, 16'h0055);
    m_reg[7] = 16'h0055;
    m_reg[0] = 16'h00AA;

    // Reset during EXEC: sequence abandoned, no done pulse
    mwrite(4, 16'h1111);
    op_rd = 3'd4; op_rn = 3'd7; op_rm = 3'd7; op_alu = 2'b00; op_shift = 2'b00; start = 1;
    tick();               // cycle k+1 (LDA)
    start = 0;
    tick();               // k+2 (LDB)
    tick();               // k+3 (EXEC)
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < N; i++) m_reg[i] = '0;
    check("rstx_busy_done", {busy, done}, 2'b00);
    check("rstx_out", datapath_out, 16'h0);
    tick();
    check("rstx_busy_done2", {busy, done}, 2'b00);
    // start two cycles after reset
    run_op(1, 0, 0, 2'b11, 2'b00);
    check("rstx_after_c", datapath_out, 16'hFFFF);
    dcount = 0;
    mread(4, rv);
    check("rstx_r4", rv, 16'h0);

    // Randomized sequenced ops against the model
    for (int i = 0; i < N; i++) mwrite(i, 16'($urandom));
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) mwrite($urandom_range(0, N - 1), 16'($urandom));
      run_op($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if (it % 3 == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        mread(r, rv);
        check("rand_readback", rv, m_reg[r]);
      end
    end

    // WIDTH=8, NREGS=16: NOT of R15 into R9, extra starts while busy ignored
    writenum8 = 4'd15; datapath_in8 = 8'h0F; vsel8 = 1; write8 = 1;
    tick();
    write8 = 0; vsel8 = 0; datapath_in8 = '0;
    op_rd8 = 4'd9; op_rn8 = 4'd0; op_rm8 = 4'd15; op_alu8 = 2'b11; op_shift8 = 2'b00; start8 = 1;
    tick();
    dcount = 0;
    bcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done8) dcount++;
      if (busy8) bcount++;
      if (i == 2) start8 = 0;
      tick();
    end
    check("w8_done_count", dcount, 1);
    check("w8_busy_count", bcount, 4);
    check("w8_c", datapath_out8, 8'hF0);
    check("w8_status", status_out8, 3'b100);
    readnum8 = 4'd9; loada8 = 1; tick(); loada8 = 0;
    bsel8 = 1; ALUop8 = 2'b00; loadc8 = 1; tick(); loadc8 = 0; bsel8 = 0;
    check("w8_r9", datapath_out8, 8'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_datapath.md
# param_datapath

Parametrised successor to the single-cycle 16-bit datapath: an N-register file, A/B/C pipeline registers, a shifter, a 4-op ALU and a 3-flag status register (Z, N, V). It keeps full manual control through the external control ports. It adds a built-in sequencer that runs a complete register-to-register operation (rd = rn OP shift(rm)) from a single `start` pulse, reporting `busy` and `done`. It sits between the instruction FSM and memory/IO in the CPU.

## Interface
- WIDTH, 16, datapath word width (≥ 8)
- NREGS, 8, register count (power of 2, ≥ 2); RW = log2(NREGS)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- datapath_in  in  WIDTH  external data: writeback source when vsel=1; immediate source when bsel=1
- vsel  in  1  writeback source: 1 = datapath_in, 0 = C
- writenum, readnum  in  RW  register write / read index
- write  in  1  register write enable
- loada, loadb, loadc, loads  in  1  load enables for A, B, C and status
- shift  in  2  shifter op on B
- asel, bsel  in  1  operand muxes
- ALUop  in  2  ALU op
- start  in  1  launch sequenced op (sampled only in IDLE)
- op_rd, op_rn, op_rm  in  RW  sequenced op: destination, A source, B source
- op_alu, op_shift  in  2  sequenced op: ALU op and shift
- busy  out  1  sequencer active
- done  out  1  one-cycle pulse when the sequenced op completes
- status_out  out  3  {N, V, Z}
- datapath_out  out  WIDTH  contents of C

## Operation
- Regfile: write is synchronous (on the clk edge when write=1); read is combinational on the readnum index.
- A and B load data_out at the clk edge when their load enable is set. C loads the ALU result when loadc=1. Status loads {N, V, Z} when loads=1.
- Shifter on B:
  - 00 pass
  - 01 << 1, zero fill
  - 10 >> 1 logical
  - 11 >> 1 arithmetic (MSB replicated)
- Ain = asel ? 0 : A.
- Bin = bsel ? zero-extended datapath_in[4:0] : shifter output.
- ALU ops, all results modulo 2^WIDTH:
  - 00 Ain+Bin
  - 01 Ain−Bin
  - 10 Ain&Bin
  - 11 ~Bin
- Flags:
  - Z = (result == 0)
  - N = result[WIDTH-1]
  - V = two's-complement signed overflow for add/sub; 0 for and/not
- Writeback data = vsel ? datapath_in : C.
- Sequencer FSM: IDLE → LDA → LDB → EXEC → WB → IDLE.
  - IDLE: manual ports drive the datapath. If start=1, latch the op_* fields and go to LDA.
  - LDA: readnum = op_rn, load A.
  - LDB: readnum = op_rm, load B.
  - EXEC: asel = 0, bsel = 0, shift = op_shift, ALUop = op_alu; load C and status.
  - WB: vsel = 0, writenum = op_rd, write = 1.
- While busy, all manual control inputs are ignored and the sequencer drives the internal controls. `start` is ignored when not in IDLE.
- Because writeback happens in WB, the next op can read the new rd value.

## Timing
- Reset values: all registers, A, B, C and status = 0; FSM = IDLE; busy = 0; done = 0; datapath_out = 0; status_out = 0.
- `start` sampled at edge k:
  - busy = 1 during cycles k+1..k+4 (LDA, LDB, EXEC, WB)
  - datapath_out and status valid from cycle k+4
  - regfile rd updated at the edge ending cycle k+4
  - done = 1 during cycle k+5 only; busy = 0 in that cycle
  - back-to-back: a new start can be sampled in cycle k+5, giving 5-cycle throughput
- Manual mode: each load takes effect at the next edge; datapath_out changes the cycle after loadc.
- Start and manual controls active in the same IDLE cycle: the manual loads/writes of that cycle execute, and the op is also latched.
- Reset asserted mid-sequence: next cycle FSM = IDLE, busy = done = 0, all state cleared. A pending write in WB is dropped if reset coincides with it.
- op_rd == op_rn or op_rm: allowed. Operands are read before WB, so old values are used.

## Test plan
- Reset: preload registers, then pulse reset → all outputs 0; reading any register via manual A/C path gives 0.
- Manual path, WIDTH=16: write R0=7, R1=2 (vsel=1). Load A=R0, B=R1. shift=01, ALUop=00, loadc+loads → datapath_out=11, status {0,0,0}.
- Sequenced sub: R2=5, R3=5, start with rd=4, rn=2, rm=3, op_alu=01 → busy for 4 cycles; done in cycle k+5; R4=0; Z=1.
- Overflow, WIDTH=16: R0=0x7FFF, R1=1, sequenced add → C=0x8000, {N,V,Z}={1,1,0}. Then op_shift=11 on 0x8000 → 0xC000.
- Reset asserted during EXEC → rd unchanged, busy=0, done never pulses. A start applied 2 cycles after reset completes normally.
- Parametrised build, WIDTH=8, NREGS=16: sequenced NOT of R15=0x0F into R9 → R9=0xF0, N=1. Start asserted while busy is ignored, so exactly one done pulse.
